// File: rtl/fir_coef_bank.sv
// fir_coef_bank: double-buffered FIR coefficient store.
// The host writes taps into a shadow bank and then requests a commit. The
// active bank, which drives coef_flat, is replaced from the shadow on the next
// sample_tick. Each sample therefore uses one complete, coherent coefficient set.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   sample_tick       sample-boundary strobe (the same strobe as fir_core en)
//   wr_valid/ready    tap write handshake; wr_addr selects the tap, wr_data is the value
//   commit_valid/ready request a shadow->active transfer
//   coef_flat         active bank, h[k] at [k*COEFW +: COEFW]
//   rd_addr/rd_data   registered readback of the active bank (0 when out of range)
//   pending           high while a commit waits for sample_tick
//   swap_done         one-cycle pulse after each swap
//   wr_err            one-cycle pulse after an accepted out-of-range write
//   swap_count        completed swaps, wrapping
module fir_coef_bank #(
  parameter int COEFW = 16,
  parameter int NTAPS = 16,
  parameter int ADDRW = $clog2(NTAPS),
  parameter int CNTW  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_tick,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDRW-1:0]       wr_addr,
  input  logic [COEFW-1:0]       wr_data,
  input  logic                   commit_valid,
  output logic                   commit_ready,
  output logic [NTAPS*COEFW-1:0] coef_flat,
  input  logic [ADDRW-1:0]       rd_addr,
  output logic [COEFW-1:0]       rd_data,
  output logic                   pending,
  output logic                   swap_done,
  output logic                   wr_err,
  output logic [CNTW-1:0]        swap_count
);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t           state, state_next;
  logic [COEFW-1:0] shadow [NTAPS];
  logic [COEFW-1:0] active [NTAPS];
  logic             swap;
  logic             wr_fire;
  logic             wr_in_range;
  logic             rd_in_range;

  assign wr_in_range = (int'(wr_addr) < NTAPS);
  assign rd_in_range = (int'(rd_addr) < NTAPS);
  assign wr_fire     = wr_valid && wr_ready;

  always_comb begin
    state_next   = state;
    wr_ready     = 1'b0;
    commit_ready = 1'b0;
    swap         = 1'b0;
    case (state)
      IDLE: begin
        wr_ready     = 1'b1;
        commit_ready = 1'b1;
        // A tick in the same cycle as the commit does not swap.
        if (commit_valid) state_next = PENDING;
      end
      PENDING: begin
        if (sample_tick) begin
          swap       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pending    <= 1'b0;
      swap_done  <= 1'b0;
      wr_err     <= 1'b0;
      swap_count <= '0;
      rd_data    <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      state     <= state_next;
      pending   <= (state_next == PENDING);
      swap_done <= swap;
      wr_err    <= wr_fire && !wr_in_range;
      if (wr_fire && wr_in_range) shadow[wr_addr] <= wr_data;
      if (swap) begin
        for (int unsigned i = 0; i < NTAPS; i++) active[i] <= shadow[i];
        swap_count <= swap_count + CNTW'(1);
      end
      // Read from the shadow on the swap edge so that rd_data shows the new bank
      // in the cycle right after the swap.
      if (!rd_in_range) rd_data <= '0;
      else if (swap)    rd_data <= shadow[rd_addr];
      else              rd_data <= active[rd_addr];
    end
  end

  always_comb begin
    coef_flat = '0;
    for (int unsigned k = 0; k < NTAPS; k++) coef_flat[k*COEFW +: COEFW] = active[k];
  end

endmodule

// File: tb/tb_fir_coef_bank.sv
module tb_fir_coef_bank;
  localparam int NT = 12;
  localparam int CW = 16;
  localparam int AW = 4;
  localparam int NW = 4;

  logic             clk = 1'b0;
  logic             rst, sample_tick, wr_valid, commit_valid;
  logic             wr_ready, commit_ready, pending, swap_done, wr_err;
  logic [AW-1:0]    wr_addr, rd_addr;
  logic [CW-1:0]    wr_data, rd_data;
  logic [NT*CW-1:0] coef_flat;
  logic [NW-1:0]    swap_count;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: both banks, the outstanding commit, and the
  // registered pulses and readback after each edge.
  logic [CW-1:0] sh_m [NT];
  logic [CW-1:0] ac_m [NT];
  bit            pend_m, sd_m, err_m;
  logic [CW-1:0] rd_m;
  int            cnt_m;

  fir_coef_bank #(.COEFW(CW), .NTAPS(NT), .ADDRW(AW), .CNTW(NW)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .coef_flat(coef_flat), .rd_addr(rd_addr), .rd_data(rd_data),
    .pending(pending), .swap_done(swap_done), .wr_err(wr_err), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  function automatic logic [NT*CW-1:0] flat_of_model();
    logic [NT*CW-1:0] f;
    for (int k = 0; k < NT; k++) f[k*CW +: CW] = ac_m[k];
    return f;
  endfunction

  task automatic model_edge();
    bit idle;
    if (rst) begin
      for (int i = 0; i < NT; i++) begin sh_m[i] = '0; ac_m[i] = '0; end
      pend_m = 0; sd_m = 0; err_m = 0; rd_m = '0; cnt_m = 0;
    end else begin
      idle = !pend_m;
      sd_m = pend_m && sample_tick;
      if (sd_m) begin
        for (int i = 0; i < NT; i++) ac_m[i] = sh_m[i];
        cnt_m  = (cnt_m + 1) % (1 << NW);
        pend_m = 0;
      end
      err_m = idle && wr_valid && (int'(wr_addr) >= NT);
      if (idle && wr_valid && int'(wr_addr) < NT) sh_m[wr_addr] = wr_data;
      if (idle && commit_valid) pend_m = 1;
      rd_m = (int'(rd_addr) < NT) ? ac_m[rd_addr] : '0;
    end
  endtask

  task automatic clk_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; sample_tick = 0; wr_valid = 0; commit_valid = 0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 20; c++) begin
      sample_tick = 1'($urandom); wr_valid = 1'($urandom); commit_valid = 1'($urandom);
      wr_addr = 4'($urandom); wr_data = 16'($urandom);
      clk_cycle();
    end
    for (int c = 0; c < 3; c++) begin
      rst = 1;
      sample_tick = 1'($urandom); wr_valid = 1'($urandom); commit_valid = 1'($urandom);
      clk_cycle();
      n_cmp++;
      if (coef_flat !== '0 || swap_count !== '0 || pending !== 1'b0 || wr_ready !== 1'b1 ||
          commit_ready !== 1'b1 || rd_data !== '0 || swap_done !== 1'b0 || wr_err !== 1'b0) begin
        n_bad++;
        $display("FAIL reset: coef=%h cnt=%0d pend=%b wrdy=%b crdy=%b rd=%h sd=%b err=%b, required all zero with readies 1",
                 coef_flat, swap_count, pending, wr_ready, commit_ready, rd_data, swap_done, wr_err);
      end
    end
    idle_inputs();
  endtask

  task automatic test_load_swap();
    for (int k = 0; k < NT; k++) begin
      wr_valid = 1; wr_addr = 4'(k); wr_data = 16'(16000 >> k);
      clk_cycle();
    end
    wr_valid = 0; commit_valid = 1;
    clk_cycle();
    commit_valid = 0;
    for (int c = 0; c < 10; c++) begin
      clk_cycle();
      n_cmp++;
      if (coef_flat !== '0 || pending !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_pending: coef=%h pend=%b, required coef=0 pend=1", coef_flat, pending);
      end
    end
    sample_tick = 1;
    clk_cycle();
    sample_tick = 0;
    n_cmp++;
    if (coef_flat[15:0] !== 16'd16000 || coef_flat[31:16] !== 16'd8000 ||
        coef_flat[11*CW +: CW] !== 16'd7 || swap_done !== 1'b1 || swap_count !== 4'd1 || pending !== 1'b0) begin
      n_bad++;
      $display("FAIL swap: h0=%0d h1=%0d h11=%0d sd=%b cnt=%0d pend=%b, required 16000 8000 7 1 1 0",
               coef_flat[15:0], coef_flat[31:16], coef_flat[11*CW +: CW], swap_done, swap_count, pending);
    end
    clk_cycle();
    n_cmp++;
    if (swap_done !== 1'b0) begin
      n_bad++;
      $display("FAIL swap_done_width: got %b required 0", swap_done);
    end
  endtask

  task automatic test_blocking();
    commit_valid = 1;
    clk_cycle();
    commit_valid = 0;
    wr_valid = 1; wr_addr = 4'd0; wr_data = 16'h8001;
    for (int c = 0; c < 4; c++) begin
      clk_cycle();
      n_cmp++;
      if (wr_ready !== 1'b0 || commit_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL blocked_ready: wrdy=%b crdy=%b required 0 0", wr_ready, commit_ready);
      end
    end
    sample_tick = 1;
    clk_cycle();
    sample_tick = 0;
    n_cmp++;
    if (coef_flat[15:0] !== 16'd16000 || swap_count !== 4'd2 || wr_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL blocked_shadow: h0=%h cnt=%0d wrdy=%b required 3e80 2 1", coef_flat[15:0], swap_count, wr_ready);
    end
    clk_cycle();
    wr_valid = 0;
    n_cmp++;
    if (coef_flat[15:0] !== 16'd16000) begin
      n_bad++;
      $display("FAIL write_no_active: h0=%h required 3e80", coef_flat[15:0]);
    end
    commit_valid = 1;
    clk_cycle();
    commit_valid = 0; sample_tick = 1;
    clk_cycle();
    sample_tick = 0;
    n_cmp++;
    if (coef_flat[15:0] !== 16'h8001 || swap_count !== 4'd3) begin
      n_bad++;
      $display("FAIL late_write: h0=%h cnt=%0d required 8001 3", coef_flat[15:0], swap_count);
    end
  endtask

  task automatic test_same_cycle();
    commit_valid = 1; sample_tick = 1; wr_valid = 1; wr_addr = 4'd3; wr_data = 16'd1234;
    clk_cycle();
    commit_valid = 0; sample_tick = 0; wr_valid = 0;
    n_cmp++;
    if (pending !== 1'b1 || swap_done !== 1'b0 || coef_flat[3*CW +: CW] !== 16'd2000) begin
      n_bad++;
      $display("FAIL commit_tick_same: pend=%b sd=%b h3=%0d required 1 0 2000", pending, swap_done, coef_flat[3*CW +: CW]);
    end
    sample_tick = 1;
    clk_cycle();
    sample_tick = 0;
    n_cmp++;
    if (coef_flat[3*CW +: CW] !== 16'd1234 || swap_done !== 1'b1 || swap_count !== 4'd4) begin
      n_bad++;
      $display("FAIL write_with_commit: h3=%0d sd=%b cnt=%0d required 1234 1 4", coef_flat[3*CW +: CW], swap_done, swap_count);
    end
  endtask

  task automatic test_err_readback();
    wr_valid = 1; wr_addr = 4'd13; wr_data = 16'h7777;
    clk_cycle();
    wr_valid = 0;
    n_cmp++;
    if (wr_err !== 1'b1) begin
      n_bad++;
      $display("FAIL wr_err_pulse: got %b required 1", wr_err);
    end
    clk_cycle();
    n_cmp++;
    if (wr_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_err_width: got %b required 0", wr_err);
    end
    commit_valid = 1;
    clk_cycle();
    commit_valid = 0; sample_tick = 1;
    clk_cycle();
    sample_tick = 0;
    n_cmp++;
    if (coef_flat[15:0] !== 16'h8001 || coef_flat[3*CW +: CW] !== 16'd1234 ||
        coef_flat[11*CW +: CW] !== 16'd7 || coef_flat !== flat_of_model()) begin
      n_bad++;
      $display("FAIL oob_bank_unchanged: got %h required %h", coef_flat, flat_of_model());
    end
    rd_addr = 4'd1;
    clk_cycle();
    n_cmp++;
    if (rd_data !== 16'd8000) begin
      n_bad++;
      $display("FAIL readback_1: got %0d required 8000", rd_data);
    end
    rd_addr = 4'd14;
    clk_cycle();
    n_cmp++;
    if (rd_data !== 16'd0) begin
      n_bad++;
      $display("FAIL readback_oob: got %h required 0", rd_data);
    end
    rd_addr = 4'd0;
    clk_cycle();
    n_cmp++;
    if (rd_data !== 16'h8001) begin
      n_bad++;
      $display("FAIL readback_0: got %h required 8001", rd_data);
    end
  endtask

  task automatic test_reset_pending();
    commit_valid = 1;
    clk_cycle();
    commit_valid = 0;
    n_cmp++;
    if (pending !== 1'b1) begin
      n_bad++;
      $display("FAIL pend_before_rst: got %b required 1", pending);
    end
    rst = 1;
    clk_cycle();
    rst = 0; sample_tick = 1;
    clk_cycle();
    sample_tick = 0;
    n_cmp++;
    if (swap_done !== 1'b0 || coef_flat !== '0 || swap_count !== '0 || pending !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_pending: sd=%b coef=%h cnt=%0d pend=%b required 0 0 0 0",
               swap_done, coef_flat, swap_count, pending);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      sample_tick  = ($urandom_range(0, 9) < 4);
      wr_valid     = 1'($urandom);
      commit_valid = ($urandom_range(0, 4) == 0);
      wr_addr      = 4'($urandom);
      wr_data      = 16'($urandom);
      rd_addr      = 4'($urandom);
      clk_cycle();
      n_cmp++;
      if (coef_flat !== flat_of_model() || rd_data !== rd_m || pending !== pend_m ||
          wr_ready !== !pend_m || commit_ready !== !pend_m || swap_done !== sd_m ||
          wr_err !== err_m || swap_count !== NW'(cnt_m)) begin
        n_bad++;
        $display("FAIL random cyc %0d: coef=%h rd=%h pend=%b wrdy=%b sd=%b err=%b cnt=%0d; required coef=%h rd=%h pend=%b sd=%b err=%b cnt=%0d",
                 c, coef_flat, rd_data, pending, wr_ready, swap_done, wr_err, swap_count,
                 flat_of_model(), rd_m, pend_m, sd_m, err_m, cnt_m % (1 << NW));
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    clk_cycle();
    rst = 0;
    test_reset();
    test_load_swap();
    test_blocking();
    test_same_cycle();
    test_err_readback();
    test_reset_pending();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_coef_bank.md
Name: fir_coef_bank

Overview:
- Double-buffered coefficient store that sits directly upstream of fir_core and drives its coef_flat input.
- Host writes individual taps into a shadow bank through a valid/ready port, then requests a commit.
- The active bank (driven on coef_flat) is replaced from the shadow only at a sample boundary, marked by sample_tick (the same strobe that drives fir_core en).
- Every sample is therefore convolved with exactly one coherent coefficient set; no half-updated filters.

Parameters:
- COEFW, 16, coefficient width in bits (signed, Q1.15 at default).
- NTAPS, 16, number of taps; any value >= 2, not required to be a power of two.
- ADDRW, $clog2(NTAPS), tap address width.
- CNTW, 16, width of the swap counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- sample_tick  in  1  sample-boundary strobe, same signal as fir_core en.
- wr_valid  in  1  tap write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  ADDRW  tap index; 0 = h[0].
- wr_data  in  COEFW  signed coefficient value.
- commit_valid  in  1  request shadow->active transfer.
- commit_ready  out  1  commit accepted when commit_valid && commit_ready.
- coef_flat  out  NTAPS*COEFW  active bank; h[k] at bits [k*COEFW +: COEFW].
- rd_addr  in  ADDRW  active-bank readback index.
- rd_data  out  COEFW  active[rd_addr], registered.
- pending  out  1  high while a commit waits for sample_tick.
- swap_done  out  1  one-cycle pulse after each swap.
- wr_err  out  1  one-cycle pulse on an accepted out-of-range write.
- swap_count  out  CNTW  number of completed swaps; wraps.

Behaviour:
- Reset (rst high at a clk edge): both banks all zero, FSM to IDLE.
  - Outputs after reset: coef_flat = 0, rd_data = 0, pending = 0, swap_done = 0, wr_err = 0, swap_count = 0, wr_ready = 1, commit_ready = 1.
  - rst overrides all other inputs.
- FSM states: IDLE, PENDING.
  - IDLE: wr_ready = 1, commit_ready = 1. An accepted commit moves to PENDING at that edge.
  - PENDING: wr_ready = 0, commit_ready = 0, pending = 1. At the first edge where sample_tick = 1, the entire shadow bank is copied to the active bank in one clock edge and the FSM returns to IDLE.
  - pending is a registered copy of state == PENDING.
- Swap timing:
  - fir_core samples the old coef_flat at the swap edge, so the tick that triggers the swap still uses the old set.
  - The next sample_tick uses the new set.
  - swap_done is high for the single cycle following the swap edge.
  - swap_count increments at the swap edge and wraps modulo 2^CNTW.
- Commit and sample_tick high in the same IDLE cycle: the commit is accepted, but that tick does not swap. The swap happens on the next sample_tick.
- Write and commit accepted in the same cycle: the write lands in the shadow at that edge and is included in the pending swap.
- Shadow persistence: the shadow bank keeps its contents after a swap, so incremental edits followed by a recommit are valid.
- Out-of-range write (wr_addr >= NTAPS): the write is accepted, the shadow is unchanged, and wr_err pulses for one cycle after the edge.
- Back-to-back writes: one accepted write per cycle is sustained in IDLE.
- Readback: rd_data = active[rd_addr] with 1-cycle latency. An out-of-range rd_addr returns 0.
  - If a swap occurs, rd_data reflects the new bank from the cycle after the swap edge.
- No arithmetic on coefficients: values are stored and forwarded bit-exact.
- Reset mid-PENDING: the commit is discarded, both banks are zeroed, and no swap_done is generated.
- coef_flat changes only at the reset edge or the swap edge. It never changes on a write.

Test Plan:
- Reset: assert rst for 3 cycles mid-traffic -> coef_flat = 0, swap_count = 0, pending = 0, wr_ready = 1, commit_ready = 1.
- Load and swap:
  - Write h[k] = 16000 >>> k for k = 0..15, then commit, holding sample_tick low for 10 cycles -> coef_flat stays 0 and pending = 1.
  - Pulse sample_tick -> next cycle coef_flat[15:0] = 16000, [31:16] = 8000, swap_done = 1 for exactly one cycle, swap_count = 1.
- Blocking during PENDING: hold wr_valid = 1 (addr 0, data -32767) while pending -> wr_ready = 0 and the shadow is unaffected. After the swap the write is accepted. Commit plus tick -> h[0] = -32767.
- Same-cycle corner cases:
  - commit_valid and sample_tick high together in IDLE -> no swap that cycle; swap occurs on the next tick.
  - Write addr 3 = 1234 in the same cycle as the commit -> the swapped bank has h[3] = 1234.
- Errors and readback:
  - NTAPS = 12: write addr 13 -> wr_err pulses and the bank is unchanged.
  - rd_addr = 1 -> rd_data = 8000 one cycle later.
  - rd_addr = 14 -> rd_data = 0.
- End-to-end with fir_core:
  - Pass-through set (h[0] = 32767) and a 1 kHz sine; commit the inverting set (h[0] = -32767) mid-stream.
  - Expected: dout flips sign exactly at the first sample after the swap tick, with no mixed-coefficient sample.
  - Reset mid-PENDING -> no swap_done, and dout decays to 0.
